// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and helpers for the pipe_fifo slice
package pipe_pkg;

    localparam int PIPE_DEPTH_DEF = 4;
    localparam int PIPE_DW_DEF    = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_fifo_mem.sv
// rtl/pipe_fifo_mem.sv - DEPTH x DW register array, sync write, async read, reset to zero
module pipe_fifo_mem
    import pipe_pkg::*;
#(
    parameter int DW    = PIPE_DW_DEF,
    parameter int DEPTH = PIPE_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_i,
    input  logic [clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW-1:0]           wdata_i,
    input  logic [clog2(DEPTH)-1:0] raddr_i,
    output logic [DW-1:0]           rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // First-word fall-through: the head entry is visible without a read strobe.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_fifo.sv
// rtl/pipe_fifo.sv - elastic output buffer with irdy driven from registered state only
module pipe_fifo
    import pipe_pkg::*;
#(
    parameter int DW    = PIPE_DW_DEF,
    parameter int DEPTH = PIPE_DEPTH_DEF,
    parameter int AFULL = DEPTH - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ival,
    output logic                  irdy,
    input  logic [DW-1:0]         idata,
    output logic                  oval,
    input  logic                  ordy,
    output logic [DW-1:0]         odata,
    output logic [clog2(DEPTH):0] count,
    output logic                  afull
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pipe_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((AFULL < 1) || (AFULL > DEPTH)) begin : g_bad_afull
        $error("pipe_fifo: AFULL must lie in 1..DEPTH");
    end

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          iack;
    logic          oack;

    // irdy looks only at count_q, so a full buffer refuses a push even when it pops.
    assign irdy  = (count_q != CW'(DEPTH));
    assign oval  = (count_q != '0);
    assign afull = (count_q >= CW'(AFULL));
    assign count = count_q;

    assign iack = ival & irdy;
    assign oack = oval & ordy;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (iack) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (oack) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({iack, oack})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    pipe_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (iack),
        .waddr_i (wptr_q),
        .wdata_i (idata),
        .raddr_i (rptr_q),
        .rdata_o (odata)
    );

    a_irdy_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
        irdy == (count != CW'(DEPTH)));
    a_oval_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
        oval == (count != '0));
    a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));

endmodule

// File: tb/tb_pipe_fifo.sv
// tb/tb_pipe_fifo.sv - directed table-driven bench for pipe_fifo
module tb_pipe_fifo;

    logic       clk;
    logic       rst_n;
    logic       ival;
    logic       irdy;
    logic [7:0] idata;
    logic       oval;
    logic       ordy;
    logic [7:0] odata;
    logic [2:0] count;
    logic       afull;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ival;
        logic [7:0] idata;
        logic       ordy;
        logic       e_irdy;
        logic       e_oval;
        logic [7:0] e_odata;
        logic [2:0] e_count;
        logic       e_afull;
    } vec_t;

    vec_t vq[$];

    pipe_fifo #(
        .DW    (8),
        .DEPTH (4),
        .AFULL (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ival  (ival),
        .irdy  (irdy),
        .idata (idata),
        .oval  (oval),
        .ordy  (ordy),
        .odata (odata),
        .count (count),
        .afull (afull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic iv, input logic [7:0] id, input logic od,
                           input logic e_irdy, input logic e_oval, input logic [7:0] e_odata,
                           input logic [2:0] e_count, input logic e_afull);
        vec_t v;
        v.ival    = iv;
        v.idata   = id;
        v.ordy    = od;
        v.e_irdy  = e_irdy;
        v.e_oval  = e_oval;
        v.e_odata = e_odata;
        v.e_count = e_count;
        v.e_afull = e_afull;
        vq.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        ival  = 1'b0;
        idata = 8'h00;
        ordy  = 1'b0;

        // Outputs in each row reflect state before that row's rising edge.
        add_vec(1, 8'h11, 0, 1, 0, 8'h00, 3'd0, 0);
        add_vec(1, 8'h22, 0, 1, 1, 8'h11, 3'd1, 0);
        add_vec(1, 8'h33, 0, 1, 1, 8'h11, 3'd2, 0);
        add_vec(1, 8'h44, 0, 1, 1, 8'h11, 3'd3, 1);
        add_vec(1, 8'h55, 0, 0, 1, 8'h11, 3'd4, 1);
        add_vec(1, 8'h55, 0, 0, 1, 8'h11, 3'd4, 1);
        add_vec(0, 8'h00, 1, 0, 1, 8'h11, 3'd4, 1);
        add_vec(0, 8'h00, 1, 1, 1, 8'h22, 3'd3, 1);
        add_vec(0, 8'h00, 1, 1, 1, 8'h33, 3'd2, 0);
        add_vec(0, 8'h00, 1, 1, 1, 8'h44, 3'd1, 0);
        add_vec(0, 8'h00, 0, 1, 0, 8'h11, 3'd0, 0);
        add_vec(1, 8'h61, 0, 1, 0, 8'h11, 3'd0, 0);
        add_vec(1, 8'h62, 0, 1, 1, 8'h61, 3'd1, 0);
        add_vec(1, 8'h63, 0, 1, 1, 8'h61, 3'd2, 0);
        add_vec(1, 8'h64, 0, 1, 1, 8'h61, 3'd3, 1);
        add_vec(1, 8'h66, 1, 0, 1, 8'h61, 3'd4, 1);
        add_vec(1, 8'h66, 0, 1, 1, 8'h62, 3'd3, 1);
        add_vec(0, 8'h00, 0, 0, 1, 8'h62, 3'd4, 1);
        add_vec(0, 8'h00, 1, 0, 1, 8'h62, 3'd4, 1);
        add_vec(0, 8'h00, 1, 1, 1, 8'h63, 3'd3, 1);
        add_vec(0, 8'h00, 1, 1, 1, 8'h64, 3'd2, 0);
        add_vec(0, 8'h00, 1, 1, 1, 8'h66, 3'd1, 0);
        add_vec(0, 8'h00, 1, 1, 0, 8'h62, 3'd0, 0);
        add_vec(0, 8'h00, 0, 1, 0, 8'h62, 3'd0, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_irdy",  irdy,  1);
        chk("reset_oval",  oval,  0);
        chk("reset_odata", odata, 8'h00);
        chk("reset_count", count, 0);
        chk("reset_afull", afull, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            ival  = vq[i].ival;
            idata = vq[i].idata;
            ordy  = vq[i].ordy;
            #1;
            chk($sformatf("vec%0d_irdy", i),  irdy,  vq[i].e_irdy);
            chk($sformatf("vec%0d_oval", i),  oval,  vq[i].e_oval);
            chk($sformatf("vec%0d_odata", i), odata, vq[i].e_odata);
            chk($sformatf("vec%0d_count", i), count, vq[i].e_count);
            chk($sformatf("vec%0d_afull", i), afull, vq[i].e_afull);
        end

        // Streaming: one push and one pop per cycle after a single-cycle fill.
        for (int c = 0; c <= 100; c++) begin
            @(negedge clk);
            ival  = (c < 100);
            idata = 8'(c);
            ordy  = 1'b1;
            #1;
            if (c == 0) begin
                chk("stream_first_oval", oval, 0);
            end else begin
                chk($sformatf("stream%0d_oval", c),  oval,  1);
                chk($sformatf("stream%0d_count", c), count, 1);
                chk($sformatf("stream%0d_odata", c), odata, 32'(c - 1));
            end
        end
        @(negedge clk);
        ival = 1'b0;
        ordy = 1'b0;
        #1;
        chk("stream_drained_count", count, 0);

        // Wrap-around: 30 entries through a 4-deep ring.
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                ival  = 1'b1;
                idata = 8'(r * 16 + k);
                ordy  = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                ival = 1'b0;
                ordy = 1'b1;
                #1;
                chk($sformatf("wrap%0d_%0d_oval", r, k),  oval,  1);
                chk($sformatf("wrap%0d_%0d_odata", r, k), odata, 32'(r * 16 + k));
            end
        end
        @(negedge clk);
        ordy = 1'b0;
        #1;
        chk("wrap_end_count", count, 0);
        chk("wrap_end_oval",  oval,  0);

        // Reset mid-stream clears contents without waiting for a clock edge.
        @(negedge clk);
        ival  = 1'b1;
        idata = 8'h71;
        @(negedge clk);
        idata = 8'h72;
        @(negedge clk);
        ival = 1'b0;
        #1;
        chk("midrst_pre_count", count, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_oval",  oval,  0);
        chk("midrst_count", count, 0);
        chk("midrst_odata", odata, 8'h00);
        chk("midrst_irdy",  irdy,  1);
        chk("midrst_afull", afull, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ival  = 1'b1;
        idata = 8'hA5;
        #1;
        chk("postrst_pre_oval", oval, 0);
        @(negedge clk);
        ival = 1'b0;
        #1;
        chk("postrst_oval",  oval,  1);
        chk("postrst_odata", odata, 8'hA5);
        chk("postrst_count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
